batch_affine_reduction: RTL and testbench
=========================================

// Module: batch_affine_reduction
// PURPOSE
//   Converts N_PTS projective points (X:Y:Z) over GF(P) to affine (X/Z, Y/Z) with one shared
//   field inversion (Montgomery batch trick), optionally mapping x, y to the even representative.
//   Sits after the point-multiply core and amortises the costly inverse over a batch.
//   Uses one mod-P Montgomery multiplier (MM) and one Montgomery-domain inverter (INV), time-shared.
// PARAMETERS
//   W        255               field element width
//   N_PTS    4                 points per batch, >=1
//   P        2^255-19          field modulus, odd, < 2^W
//   R2       R^2 mod P (361)   Montgomery constant, R = 2^W
//   EVEN_EN  1                 1: replace odd results v by P-v; 0: no fix-up
// PORTS
//   i_clk    in   1        clock
//   i_rst    in   1        synchronous, active-high reset
//   i_start  in   1        one-cycle request; inputs sampled same cycle
//   i_x      in   N_PTS*W  X coords; point k at [k*W +: W]; canonical (<P), not checked
//   i_y      in   N_PTS*W  Y coords, same packing
//   i_z      in   N_PTS*W  Z coords, same packing
//   o_busy   out  1        high from cycle after accepted start until o_done cycle inclusive
//   o_done   out  1        one-cycle pulse, results valid
//   o_err    out  1        valid with o_done: some Z was zero
//   o_x      out  N_PTS*W  affine x, same packing
//   o_y      out  N_PTS*W  affine y, same packing
// BEHAVIOUR
//   Reset: every output 0, FSM in IDLE, all internal registers cleared; MM/INV reset with the block.
//   Unit semantics: MM(a,b)=a*b*R^-1 mod P; INV(a)=a^-1*R^2 mod P. Next op starts the cycle after
//     the previous op's finished pulse; exactly one op in flight at any time.
//   Handshake: i_start honoured only in IDLE; ignored while o_busy=1. Outputs hold until next done.
//   FSM: IDLE -> CHECK -> PRE -> PREFIX -> INV -> BACK -> OUT -> FIX -> DONE -> IDLE.
//     CHECK (1 cycle): if any z_k==0: o_x=o_y=0, o_err=1, go DONE. Else o_err=0.
//     PRE:    z'_k = MM(z_k, R2) = z_k*R, k=0..N-1.
//     PREFIX: c_0 = z'_0; c_k = MM(c_{k-1}, z'_k), k=1..N-1 (c_k = z_0..z_k * R).
//     INV:    u = INV(c_{N-1}).
//     BACK:   for k=N-1 downto 1: zi_k = MM(u, c_{k-1}); then u = MM(u, z'_k). Finally zi_0 = u.
//             (zi_k = z_k^-1 * R).
//     OUT:    per k ascending: x_k = MM(x_k, zi_k), then y_k = MM(y_k, zi_k).
//     FIX (1 cycle): if EVEN_EN, each odd x_k -> P-x_k, each odd y_k -> P-y_k (0 stays 0).
//     DONE (1 cycle): o_done=1, o_x/o_y/o_err registered; back to IDLE.
//   Op count: 5*N_PTS-3 MM + 1 INV. N_PTS=1: PREFIX, BACK loops empty (c_0=z'_0, zi_0=u).
//   Latency start->o_done = 3 + sum(unit latencies) + per-op handoff cycles; fixed for a given N_PTS.
//   Storage: latched x,y (N*W each), z', c, zi (N*W each), u, index counter clog2(N_PTS).
//   Reset mid-operation: abort immediately, outputs 0, no o_done; next start runs normally.
//   Start on the o_done cycle is ignored (FSM not yet in IDLE).
//   All arithmetic mod P; P-v computed on W bits, never overflows for 0<v<P.
// TESTING
//   N_PTS=1: x=2,y=4,z=2 -> x=1 odd -> o_x=P-1, o_y=2, o_err=0, single o_done pulse.
//   N_PTS=1: x=2,y=6,z=P-1 -> x=P-2 odd -> o_x=2; y=P-6 odd -> o_y=6.
//   N_PTS=4, all z=1, x={10,20,30,40}, y={2,4,6,8} -> outputs equal inputs; then z={3,5,7,9},
//     x_k=y_k=6*z_k -> all results 6; compare with golden model.
//   N_PTS=4, z_2=0 -> o_err=1, o_x=o_y=0, o_done 2 cycles after start, no MM/INV op started.
//   EVEN_EN=0: x=3,y=5,z=1 -> o_x=3, o_y=5.
//   Start pulse while busy ignored (one o_done only); i_rst mid-BACK -> outputs 0, IDLE, no o_done.

Source files
------------

// File: rtl/batch_affine_reduction.sv
// batch_affine_reduction
//   Converts a batch of N_PTS projective points (X:Y:Z) over GF(P) into affine
//   coordinates (X/Z, Y/Z). It uses the Montgomery batch trick, so the whole batch
//   shares a single field inversion. When EVEN_EN is set, each odd result v is
//   replaced by P-v so that the even representative is returned.
//   One bit-serial Montgomery multiplier and one binary-Euclid inverter are
//   time-shared, and only one operation is ever in flight.
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        one-cycle request, i_x/i_y/i_z sampled in the same cycle (IDLE only)
//   i_x,i_y,i_z    N_PTS packed W-bit coordinates, point k at [k*W +: W]
//   o_busy         high from the cycle after an accepted start through the o_done cycle
//   o_done         one-cycle pulse, o_x/o_y/o_err valid
//   o_err          some Z was zero (o_x/o_y forced to 0)
//   o_x,o_y        affine results, same packing as the inputs

// Montgomery multiplier: o_res = a*b*2^-W mod P, one bit of a per cycle.
module bar_mont_mul #(
    parameter int         W = 255,
    parameter logic [W-1:0] P = {W{1'b1}} - W'(18)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_res
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  a_reg, b_reg, res_reg;
    logic [W:0]    s_reg, s_next;
    logic [W+1:0]  t1;
    logic [CW-1:0] cnt_reg;
    logic          run_reg, done_reg;

    // The partial sum stays below 2P, so W+2 bits are enough before the halving.
    assign t1     = {1'b0, s_reg} + (a_reg[0] ? {2'b00, b_reg} : '0);
    assign s_next = (W+1)'((t1 + (t1[0] ? {2'b00, P} : '0)) >> 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            cnt_reg  <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
            res_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (i_start) begin
                a_reg   <= i_a;
                b_reg   <= i_b;
                s_reg   <= '0;
                cnt_reg <= '0;
                run_reg <= 1'b1;
            end else if (run_reg) begin
                a_reg   <= a_reg >> 1;
                s_reg   <= s_next;
                cnt_reg <= cnt_reg + CW'(1);
                if (cnt_reg == CW'(W - 1)) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                    res_reg  <= (s_next >= {1'b0, P}) ? W'(s_next - {1'b0, P}) : W'(s_next);
                end
            end
        end
    end

    assign o_done = done_reg;
    assign o_res  = res_reg;
endmodule

// Montgomery-domain inverter: o_res = a^-1 * R^2 mod P (a != 0).
// Binary extended Euclid with x1 seeded by R2 keeps a*x1 == u*R2 and a*x2 == v*R2 (mod P).
module bar_mont_inv #(
    parameter int         W  = 255,
    parameter logic [W-1:0] P  = {W{1'b1}} - W'(18),
    parameter logic [W-1:0] R2 = W'(361)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    output logic         o_done,
    output logic [W-1:0] o_res
);
    logic [W-1:0] u_reg, v_reg, x1_reg, x2_reg, res_reg;
    logic         run_reg, done_reg;

    function automatic logic [W-1:0] half_mod(input logic [W-1:0] x);
        return W'(({1'b0, x} + (x[0] ? {1'b0, P} : '0)) >> 1);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : W'({1'b0, a} + {1'b0, P} - {1'b0, b});
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            u_reg    <= '0;
            v_reg    <= '0;
            x1_reg   <= '0;
            x2_reg   <= '0;
            run_reg  <= 1'b0;
            done_reg <= 1'b0;
            res_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (i_start) begin
                u_reg   <= i_a;
                v_reg   <= P;
                x1_reg  <= R2;
                x2_reg  <= '0;
                run_reg <= 1'b1;
            end else if (run_reg) begin
                if (u_reg == W'(1) || v_reg == W'(1) || u_reg == '0) begin
                    // A zero operand cannot reach here; it just terminates with 0.
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                    res_reg  <= (u_reg == W'(1)) ? x1_reg : ((v_reg == W'(1)) ? x2_reg : '0);
                end else if (!u_reg[0]) begin
                    u_reg  <= u_reg >> 1;
                    x1_reg <= half_mod(x1_reg);
                end else if (!v_reg[0]) begin
                    v_reg  <= v_reg >> 1;
                    x2_reg <= half_mod(x2_reg);
                end else if (u_reg >= v_reg) begin
                    u_reg  <= u_reg - v_reg;
                    x1_reg <= sub_mod(x1_reg, x2_reg);
                end else begin
                    v_reg  <= v_reg - u_reg;
                    x2_reg <= sub_mod(x2_reg, x1_reg);
                end
            end
        end
    end

    assign o_done = done_reg;
    assign o_res  = res_reg;
endmodule

module batch_affine_reduction #(
    parameter int         W       = 255,
    parameter int         N_PTS   = 4,
    parameter logic [W-1:0] P       = {W{1'b1}} - W'(18),
    parameter logic [W-1:0] R2      = W'(361),
    parameter bit         EVEN_EN = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [N_PTS*W-1:0] i_x,
    input  logic [N_PTS*W-1:0] i_y,
    input  logic [N_PTS*W-1:0] i_z,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [N_PTS*W-1:0] o_x,
    output logic [N_PTS*W-1:0] o_y
);
    localparam int IW = (N_PTS > 1) ? $clog2(N_PTS) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_PTS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_PRE, S_PREFIX, S_INV, S_BACK, S_OUT, S_FIX, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [W-1:0] x_reg  [N_PTS];
    logic [W-1:0] y_reg  [N_PTS];
    logic [W-1:0] zp_reg [N_PTS];   // z, then z*R after PRE
    logic [W-1:0] c_reg  [N_PTS];   // prefix products (Montgomery form)
    logic [W-1:0] zi_reg [N_PTS];   // z^-1 * R
    logic [W-1:0] u_reg;
    logic [IW-1:0] idx_reg, idx_m1;
    logic          ph_reg;          // BACK: 0 = zi, 1 = u update; OUT: 0 = x, 1 = y
    logic          issued_reg;      // the current state's op has been started

    logic [N_PTS*W-1:0] x_out_reg, y_out_reg, fix_x, fix_y;
    logic               err_reg;
    logic [N_PTS-1:0]   zero_vec;
    logic               any_zero;

    logic         mm_start, mm_done, inv_start, inv_done;
    logic [W-1:0] mm_a, mm_b, mm_res, inv_res;

    assign idx_m1 = idx_reg - IW'(1);

    for (genvar gi = 0; gi < N_PTS; gi++) begin : g_pt
        assign zero_vec[gi]         = (zp_reg[gi] == '0);
        assign fix_x[gi*W +: W] = (EVEN_EN && x_reg[gi][0]) ? P - x_reg[gi] : x_reg[gi];
        assign fix_y[gi*W +: W] = (EVEN_EN && y_reg[gi][0]) ? P - y_reg[gi] : y_reg[gi];
    end
    assign any_zero = |zero_vec;

    bar_mont_mul #(.W(W), .P(P)) u_mm (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(mm_start),
        .i_a(mm_a), .i_b(mm_b), .o_done(mm_done), .o_res(mm_res)
    );

    bar_mont_inv #(.W(W), .P(P), .R2(R2)) u_inv (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(inv_start),
        .i_a(c_reg[N_PTS-1]), .o_done(inv_done), .o_res(inv_res)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next state and operand steering; each op is issued once on entry to its slot.
    always_comb begin
        state_next = state_reg;
        mm_start   = 1'b0;
        inv_start  = 1'b0;
        mm_a       = '0;
        mm_b       = '0;
        case (state_reg)
            S_IDLE:  if (i_start) state_next = S_CHECK;
            S_CHECK: state_next = any_zero ? S_DONE : S_PRE;
            S_PRE: begin
                mm_start = !issued_reg;
                mm_a     = zp_reg[idx_reg];
                mm_b     = R2;
                if (mm_done && idx_reg == LAST) state_next = (N_PTS == 1) ? S_INV : S_PREFIX;
            end
            S_PREFIX: begin
                mm_start = !issued_reg;
                mm_a     = c_reg[idx_m1];
                mm_b     = zp_reg[idx_reg];
                if (mm_done && idx_reg == LAST) state_next = S_INV;
            end
            S_INV: begin
                inv_start = !issued_reg;
                if (inv_done) state_next = (N_PTS == 1) ? S_OUT : S_BACK;
            end
            S_BACK: begin
                mm_start = !issued_reg;
                mm_a     = u_reg;
                mm_b     = ph_reg ? zp_reg[idx_reg] : c_reg[idx_m1];
                if (mm_done && ph_reg && idx_reg == IW'(1)) state_next = S_OUT;
            end
            S_OUT: begin
                mm_start = !issued_reg;
                mm_a     = ph_reg ? y_reg[idx_reg] : x_reg[idx_reg];
                mm_b     = zi_reg[idx_reg];
                if (mm_done && ph_reg && idx_reg == LAST) state_next = S_FIX;
            end
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_PTS; k++) begin
                x_reg[k]  <= '0;
                y_reg[k]  <= '0;
                zp_reg[k] <= '0;
                c_reg[k]  <= '0;
                zi_reg[k] <= '0;
            end
            u_reg      <= '0;
            idx_reg    <= '0;
            ph_reg     <= 1'b0;
            issued_reg <= 1'b0;
            x_out_reg  <= '0;
            y_out_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (mm_start || inv_start) issued_reg <= 1'b1;
            if (mm_done || inv_done)   issued_reg <= 1'b0;
            case (state_reg)
                S_IDLE: if (i_start) begin
                    for (int k = 0; k < N_PTS; k++) begin
                        x_reg[k]  <= i_x[k*W +: W];
                        y_reg[k]  <= i_y[k*W +: W];
                        zp_reg[k] <= i_z[k*W +: W];
                    end
                    idx_reg <= '0;
                    ph_reg  <= 1'b0;
                end
                S_CHECK: begin
                    err_reg <= any_zero;
                    if (any_zero) begin
                        x_out_reg <= '0;
                        y_out_reg <= '0;
                    end
                end
                S_PRE: if (mm_done) begin
                    zp_reg[idx_reg] <= mm_res;
                    if (idx_reg == '0) c_reg[0] <= mm_res;
                    idx_reg <= (idx_reg == LAST) ? IW'(1) : idx_reg + IW'(1);
                end
                S_PREFIX: if (mm_done) begin
                    c_reg[idx_reg] <= mm_res;
                    idx_reg        <= idx_reg + IW'(1);
                end
                S_INV: if (inv_done) begin
                    u_reg  <= inv_res;
                    ph_reg <= 1'b0;
                    if (N_PTS == 1) begin
                        zi_reg[0] <= inv_res;
                        idx_reg   <= '0;
                    end else begin
                        idx_reg <= LAST;
                    end
                end
                S_BACK: if (mm_done) begin
                    if (!ph_reg) begin
                        zi_reg[idx_reg] <= mm_res;
                        ph_reg          <= 1'b1;
                    end else begin
                        u_reg  <= mm_res;
                        ph_reg <= 1'b0;
                        if (idx_reg == IW'(1)) begin
                            zi_reg[0] <= mm_res;   // remaining u is z_0^-1 * R
                            idx_reg   <= '0;
                        end else begin
                            idx_reg <= idx_reg - IW'(1);
                        end
                    end
                end
                S_OUT: if (mm_done) begin
                    if (!ph_reg) begin
                        x_reg[idx_reg] <= mm_res;
                        ph_reg         <= 1'b1;
                    end else begin
                        y_reg[idx_reg] <= mm_res;
                        ph_reg         <= 1'b0;
                        idx_reg        <= idx_reg + IW'(1);
                    end
                end
                S_FIX: begin
                    x_out_reg <= fix_x;
                    y_out_reg <= fix_y;
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state_reg != S_IDLE);
    assign o_done = (state_reg == S_DONE);
    assign o_err  = err_reg;
    assign o_x    = x_out_reg;
    assign o_y    = y_out_reg;
endmodule

// File: tb/tb_batch_affine_reduction.sv
// tb_batch_affine_reduction
//   Directed test of batch_affine_reduction. Three instances are used:
//   N_PTS=1 with the even fix-up, N_PTS=1 without it, and N_PTS=4 with it.
//   Expected values are worked out by hand over P = 2^255-19.
module tb_batch_affine_reduction;
    localparam int W = 255;
    localparam logic [W-1:0] P = {W{1'b1}} - W'(18);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // N_PTS=1, EVEN_EN=1
    logic s1 = 1'b0;
    logic [W-1:0] x1 = '0, y1 = '0, z1 = '0, ox1, oy1;
    logic busy1, done1, err1;
    // N_PTS=1, EVEN_EN=0
    logic se = 1'b0;
    logic [W-1:0] xe = '0, ye = '0, ze = '0, oxe, oye;
    logic busye, donee, erre;
    // N_PTS=4, EVEN_EN=1
    logic s4 = 1'b0;
    logic [4*W-1:0] x4 = '0, y4 = '0, z4 = '0, ox4, oy4;
    logic busy4, done4, err4;

    batch_affine_reduction #(.W(W), .N_PTS(1), .EVEN_EN(1'b1)) d1 (
        .i_clk(clk), .i_rst(rst), .i_start(s1), .i_x(x1), .i_y(y1), .i_z(z1),
        .o_busy(busy1), .o_done(done1), .o_err(err1), .o_x(ox1), .o_y(oy1));
    batch_affine_reduction #(.W(W), .N_PTS(1), .EVEN_EN(1'b0)) d1e (
        .i_clk(clk), .i_rst(rst), .i_start(se), .i_x(xe), .i_y(ye), .i_z(ze),
        .o_busy(busye), .o_done(donee), .o_err(erre), .o_x(oxe), .o_y(oye));
    batch_affine_reduction #(.W(W), .N_PTS(4), .EVEN_EN(1'b1)) d4 (
        .i_clk(clk), .i_rst(rst), .i_start(s4), .i_x(x4), .i_y(y4), .i_z(z4),
        .o_busy(busy4), .o_done(done4), .o_err(err4), .o_x(ox4), .o_y(oy4));

    int n_tests = 0;
    int n_fail  = 0;
    int dc1 = 0, dce = 0, dc4 = 0;

    always @(posedge clk) begin
        if (done1) dc1 <= dc1 + 1;
        if (donee) dce <= dce + 1;
        if (done4) dc4 <= dc4 + 1;
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0:       return done1;
            1:       return donee;
            default: return done4;
        endcase
    endfunction

    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        case (which)
            0:       s1 = 1'b1;
            1:       se = 1'b1;
            default: s4 = 1'b1;
        endcase
        @(posedge clk); #1;
        s1 = 1'b0;
        se = 1'b0;
        s4 = 1'b0;
    endtask

    task automatic wait_done(input int which, input string tag);
        int  cyc = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done_of(which)) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc = i + 1;
        end
        check_val({tag, "_done_seen"}, W'(seen), W'(1));
        $display("[TB] txn %s: o_done after %0d cycles", tag, cyc);
    endtask

    task automatic check4(input string tag, input int xa[4], input int ya[4], input logic e);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("%s_x%0d", tag, k), ox4[k*W +: W], W'(xa[k]));
            check_val($sformatf("%s_y%0d", tag, k), oy4[k*W +: W], W'(ya[k]));
        end
        check_val({tag, "_err"}, W'(err4), W'(e));
    endtask

    task automatic load4(input int xa[4], input int ya[4], input int za[4]);
        for (int k = 0; k < 4; k++) begin
            x4[k*W +: W] = W'(xa[k]);
            y4[k*W +: W] = W'(ya[k]);
            z4[k*W +: W] = W'(za[k]);
        end
    endtask

    int six[4] = '{6, 6, 6, 6};
    int zz[4]  = '{0, 0, 0, 0};
    int base;
    logic hit;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy1", W'(busy1), W'(0));
        check_val("rst_done1", W'(done1), W'(0));
        check_val("rst_err1",  W'(err1),  W'(0));
        check_val("rst_ox1",   ox1, W'(0));
        check_val("rst_busy4", W'(busy4), W'(0));
        check_val("rst_ox4_3", ox4[3*W +: W], W'(0));
        rst = 1'b0;

        // 2/2 = 1 (odd -> P-1), 4/2 = 2
        x1 = W'(2); y1 = W'(4); z1 = W'(2);
        pulse_start(0);
        wait_done(0, "n1_a");
        check_val("n1_a_x",    ox1, P - W'(1));
        check_val("n1_a_y",    oy1, W'(2));
        check_val("n1_a_err",  W'(err1), W'(0));
        check_val("n1_a_busy", W'(busy1), W'(1));
        @(posedge clk); #1;
        check_val("n1_a_pulse", W'(done1), W'(0));
        check_val("n1_a_idle",  W'(busy1), W'(0));
        check_val("n1_a_count", W'(dc1), W'(1));

        // z = -1: x = P-2 (odd) -> 2, y = P-6 (odd) -> 6
        x1 = W'(2); y1 = W'(6); z1 = P - W'(1);
        pulse_start(0);
        wait_done(0, "n1_b");
        check_val("n1_b_x", ox1, W'(2));
        check_val("n1_b_y", oy1, W'(6));

        // No fix-up: odd results stay odd
        xe = W'(3); ye = W'(5); ze = W'(1);
        pulse_start(1);
        wait_done(1, "ne_a");
        check_val("ne_a_x", oxe, W'(3));
        check_val("ne_a_y", oye, W'(5));
        xe = W'(2); ye = W'(4); ze = W'(2);
        pulse_start(1);
        wait_done(1, "ne_b");
        check_val("ne_b_x", oxe, W'(1));
        check_val("ne_b_y", oye, W'(2));

        // N_PTS=4, all z=1: outputs equal inputs
        load4('{10, 20, 30, 40}, '{2, 4, 6, 8}, '{1, 1, 1, 1});
        pulse_start(2);
        wait_done(2, "n4_z1");
        check4("n4_z1", '{10, 20, 30, 40}, '{2, 4, 6, 8}, 1'b0);

        // z_2 = 0: error, zeroed outputs, o_done two cycles after start
        load4('{18, 30, 42, 54}, '{18, 30, 42, 54}, '{3, 5, 0, 9});
        pulse_start(2);
        check_val("n4_err_early", W'(done4), W'(0));
        @(posedge clk); #1;
        check_val("n4_err_done", W'(done4), W'(1));
        check4("n4_err", zz, zz, 1'b1);
        // Start on the o_done cycle must be ignored
        s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
        check_val("n4_done_start_a", W'(busy4), W'(0));
        @(posedge clk); #1;
        check_val("n4_done_start_b", W'(busy4), W'(0));

        // z = {3,5,7,9}, x = y = 6z: every result is 6
        load4('{18, 30, 42, 54}, '{18, 30, 42, 54}, '{3, 5, 7, 9});
        pulse_start(2);
        wait_done(2, "n4_six");
        check4("n4_six", six, six, 1'b0);

        // Start while busy is ignored: result from the first request, one o_done
        base = dc1;
        x1 = W'(2); y1 = W'(4); z1 = W'(2);
        pulse_start(0);
        repeat (20) @(posedge clk);
        x1 = W'(2); y1 = W'(6); z1 = P - W'(1);
        pulse_start(0);
        wait_done(0, "n1_busy");
        check_val("n1_busy_x", ox1, P - W'(1));
        check_val("n1_busy_y", oy1, W'(2));
        repeat (1500) @(posedge clk);
        #1;
        check_val("n1_busy_count", W'(dc1 - base), W'(1));

        // Reset in the middle of BACK: outputs cleared, no o_done
        load4('{18, 30, 42, 54}, '{18, 30, 42, 54}, '{3, 5, 7, 9});
        pulse_start(2);
        hit = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (d4.state_reg == 4'd5) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("n4_reach_back", W'(hit), W'(1));
        base = dc4;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("n4_rst_busy", W'(busy4), W'(0));
        check_val("n4_rst_x0",   ox4[0 +: W], W'(0));
        check_val("n4_rst_y3",   oy4[3*W +: W], W'(0));
        repeat (6000) @(posedge clk);
        #1;
        check_val("n4_rst_nodone", W'(dc4 - base), W'(0));

        // Normal run after the abort
        pulse_start(2);
        wait_done(2, "n4_rerun");
        check4("n4_rerun", six, six, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
